// File: rtl/systolic_pkg.sv
// rtl/systolic_pkg.sv - shared types and helpers for the systolic array slice
//
// Purpose: state encoding for the operand feeder, default array geometry,
//          and the lane slice helper used by the feeder and the array top.
// Ports:   none (package).

package systolic_pkg;

   localparam int DEF_N      = 2;
   localparam int DEF_DATA_W = 8;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      CLEAR = 3'd1,
      FEED  = 3'd2,
      DRAIN = 3'd3,
      DONE  = 3'd4
   } feeder_state_t;

   // Low bit index of lane 'lane' in a packed vector of 'w'-bit lanes,
   // lane 0 at the LSBs. Use as vec[lane_lo(i, W) +: W].
   function automatic int lane_lo(input int lane, input int w);
      return lane * w;
   endfunction

endpackage

// File: rtl/skew_delay_line.sv
// rtl/skew_delay_line.sv - fixed-depth operand delay line with zero injection
//
// Purpose: DEPTH-stage shift register for one operand lane. When shifting,
//          stage 0 takes din, or zero when zero_inj is high.
// Ports:   clk      - clock, rising edge
//          clr_n    - synchronous active-low clear of every stage
//          shift_en - advance the line this cycle
//          zero_inj - load zero into stage 0 instead of din
//          din      - lane operand in
//          dout     - last stage out

module skew_delay_line #(
   parameter int DEPTH = 1,
   parameter int W     = 8
) (
   input  logic         clk,
   input  logic         clr_n,
   input  logic         shift_en,
   input  logic         zero_inj,
   input  logic [W-1:0] din,
   output logic [W-1:0] dout
);

   logic [W-1:0] stage [DEPTH];

   always_ff @(posedge clk) begin
      if (!clr_n) begin
         for (int s = 0; s < DEPTH; s++) stage[s] <= '0;
      end else if (shift_en) begin
         stage[0] <= zero_inj ? '0 : din;
         for (int s = 1; s < DEPTH; s++) stage[s] <= stage[s-1];
      end
   end

   assign dout = stage[DEPTH-1];

endmodule

// File: rtl/systolic_feeder.sv
// rtl/systolic_feeder.sv - skewed operand source and job sequencer for an N x N PE array
//
// Purpose: accepts one A column and one B row per handshake beat and emits
//          them skewed so row lane i / column lane j lag by i / j cycles.
//          Sequences each job: clear accumulators, feed K beats, drain, done.
// Ports:   clk      - clock, rising edge
//          rst      - synchronous active-low reset
//          start    - job request, sampled in IDLE only
//          k_len    - inner dimension K, latched with start
//          in_valid - a_col/b_row valid
//          in_ready - beat accepted this cycle when in_valid is also high
//          a_col    - lane i = A[i][k], lane 0 at LSBs
//          b_row    - lane j = B[k][j], lane 0 at LSBs
//          row_out  - lane i drives in1 of PE(i,0)
//          col_out  - lane j drives in2 of PE(0,j)
//          pe_clr   - accumulator clear for the PE array
//          busy     - job in progress
//          done     - one-cycle pulse, PE results final

module systolic_feeder
   import systolic_pkg::*;
#(
   parameter int N      = DEF_N,
   parameter int DATA_W = DEF_DATA_W,
   parameter int KW     = 8
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                start,
   input  logic [KW-1:0]       k_len,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [N*DATA_W-1:0] a_col,
   input  logic [N*DATA_W-1:0] b_row,
   output logic [N*DATA_W-1:0] row_out,
   output logic [N*DATA_W-1:0] col_out,
   output logic                pe_clr,
   output logic                busy,
   output logic                done
);

   // Drain covers the deepest skew (N-1) plus the trip across the array
   // to the corner PE, which accumulates 2N-1 edges after the last beat.
   localparam int DCW = (2 * N > 2) ? $clog2(2 * N) : 1;
   localparam logic [DCW-1:0] DRAIN_LAST = DCW'(2 * N - 2);

   feeder_state_t  state;
   logic [KW-1:0]  k_reg;
   logic [KW-1:0]  beat_cnt;
   logic [DCW-1:0] drain_cnt;

   logic beat;
   logic running;
   logic line_clr_n;
   logic zero_inj;

   assign in_ready = (state == FEED);
   assign pe_clr   = (state == CLEAR);
   assign busy     = (state != IDLE);
   assign done     = (state == DONE);

   assign beat     = in_valid & in_ready;
   assign running  = (state == FEED) || (state == DRAIN);

   // Lines only move while a job is feeding or draining; everywhere else
   // they sit at zero so the array sees nothing stale between jobs.
   assign line_clr_n = rst & running;
   assign zero_inj   = ~beat;

   always_ff @(posedge clk) begin
      if (!rst) begin
         state     <= IDLE;
         k_reg     <= '0;
         beat_cnt  <= '0;
         drain_cnt <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  k_reg    <= k_len;
                  beat_cnt <= '0;
                  state    <= CLEAR;
               end
            end
            CLEAR: begin
               state <= (k_reg != '0) ? FEED : DONE;
            end
            FEED: begin
               if (beat) begin
                  beat_cnt <= beat_cnt + KW'(1);
                  if (beat_cnt == k_reg - KW'(1)) begin
                     drain_cnt <= '0;
                     state     <= DRAIN;
                  end
               end
            end
            DRAIN: begin
               if (drain_cnt == DRAIN_LAST) begin
                  state <= DONE;
               end else begin
                  drain_cnt <= drain_cnt + DCW'(1);
               end
            end
            DONE: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

   for (genvar g = 0; g < N; g++) begin : g_lane
      skew_delay_line #(
         .DEPTH (g + 1),
         .W     (DATA_W)
      ) u_row (
         .clk      (clk),
         .clr_n    (line_clr_n),
         .shift_en (running),
         .zero_inj (zero_inj),
         .din      (a_col[lane_lo(g, DATA_W) +: DATA_W]),
         .dout     (row_out[lane_lo(g, DATA_W) +: DATA_W])
      );

      skew_delay_line #(
         .DEPTH (g + 1),
         .W     (DATA_W)
      ) u_col (
         .clk      (clk),
         .clr_n    (line_clr_n),
         .shift_en (running),
         .zero_inj (zero_inj),
         .din      (b_row[lane_lo(g, DATA_W) +: DATA_W]),
         .dout     (col_out[lane_lo(g, DATA_W) +: DATA_W])
      );
   end

endmodule

// File: doc/systolic_feeder.md
Name: systolic_feeder

Overview:
- Operand source for an N x N systolic multiply-accumulate PE array.
- Accepts one A column and one B row per handshake beat.
- Emits them skewed in time: row i and column j are delayed i and j cycles, so operands with matching k meet in each PE.
- Sequences the job: clears the PE accumulators, feeds K beats, drains the array, then pulses done.

Parameters:
- N, 2, array dimension (rows = columns = N).
- DATA_W, 8, operand width per lane.
- KW, 8, width of the inner-dimension length k_len.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset: synchronous, active-low.
- start  in  1  job request, sampled in IDLE only.
- k_len  in  KW  inner dimension K, sampled with start.
- in_valid  in  1  a_col/b_row valid.
- in_ready  out  1  feeder accepts a beat this cycle.
- a_col  in  N*DATA_W  lane i = A[i][k], lane 0 at LSBs.
- b_row  in  N*DATA_W  lane j = B[k][j], lane 0 at LSBs.
- row_out  out  N*DATA_W  lane i drives in1 of PE(i,0).
- col_out  out  N*DATA_W  lane j drives in2 of PE(0,j).
- pe_clr  out  1  active-high accumulator clear for the PE array.
- busy  out  1  high in any state other than IDLE.
- done  out  1  one-cycle pulse; PE results are final.

Behaviour:
- Reset (rst=0 at an edge): state IDLE, all skew stages 0, counters 0.
  - Outputs after reset: row_out=0, col_out=0, pe_clr=0, in_ready=0, busy=0, done=0.
  - Reset mid-job aborts the job; no done pulse.
- States: IDLE, CLEAR, FEED, DRAIN, DONE. All outputs are registered or derived from state only.
- IDLE:
  - start=1 latches k_len and moves to CLEAR.
  - start in any other state is ignored.
- CLEAR: one cycle with pe_clr=1, in_ready=0.
  - Next state is FEED if k_len!=0, otherwise DONE.
- FEED: in_ready=1.
  - Beat = in_valid & in_ready at an edge.
  - Each beat increments beat_cnt. On the beat where beat_cnt reaches k_len-1, go to DRAIN.
  - in_valid=0 at an edge inserts a bubble: zeros enter lane 0 of every skew line. Zero operands in both a and b leave accumulators unchanged.
- Skew lines:
  - Row lane i is a shift register of i+1 stages; column lane j has j+1 stages.
  - A beat accepted at edge E appears on row_out lane i after edge E+i, and on col_out lane j after edge E+j. Latency is 1..N cycles.
  - All stages shift every cycle in FEED and DRAIN, with 0 injected when no beat. Stages are held at 0 in IDLE/CLEAR/DONE.
- DRAIN:
  - in_ready=0; zeros are injected.
  - Lasts exactly 2N-1 cycles after the last-beat edge EL, then goes to DONE at edge EL+2N-1.
  - This is the edge where corner PE(N-1,N-1) performs its final accumulate.
- DONE: done=1 for one cycle, then IDLE.
- No arithmetic in this block. PE accumulation wraps mod 2^DATA_W, which is the array's behaviour, not the feeder's.
- k_len is held constant for the job; a change on the port after start has no effect.

Decomposition:
- Shared package systolic_pkg:
  - state encoding constants (IDLE=0, CLEAR=1, FEED=2, DRAIN=3, DONE=4);
  - default N and DATA_W;
  - lane slice helper macro/function used by both this block and the array top.
- One sub-module: skew_delay_line.
  - Parameters: DEPTH, W. Ports: synchronous active-low clear, shift-enable input, zero-inject input.
  - Instantiated 2N times with DEPTH=lane+1.

Test Plan:
- Reset: hold rst=0 for 3 cycles with random inputs -> every output 0, busy=0. After release, in_ready stays 0 until start.
- 2x2 job with back-to-back beats, driven into a 2x2 PE array model:
  - Stimulus: start, k_len=2. Beat0 a_col={A00=1,A10=3}, b_row={5,6}. Beat1 a_col={2,4}, b_row={7,8}.
  - Required response: pe_clr exactly one cycle before in_ready rises; row_out lane1 lags lane0 by one cycle.
  - done is high in the cycle after edge EL+3; array result = [[19,22],[43,50]].
- Bubble: same data with in_valid=0 for one cycle between beats -> zeros on row_out lane0/col_out lane0 in that slot, same results, done one cycle later than the no-bubble case.
- k_len=0: start -> CLEAR (pe_clr=1) then DONE (done=1) on the next cycle. in_ready is never 1; results are 0.
- start asserted during FEED with k_len=5 -> ignored, job completes with the original K. A second start in IDLE after done starts a fresh job and re-pulses pe_clr.
- rst=0 for one cycle mid-FEED -> next cycle IDLE with all skew outputs 0, and no done pulse follows.
